// File: rtl/tt_user_sel_pkg.sv
// Shared FSM state type and default timing for tt_user_sel.
// SYNC_STAGES is 2 when TT_USER_SEL_SYNC_EN is defined, otherwise 1.
package tt_user_sel_pkg;

   typedef enum logic [1:0] {
      CLEAR  = 2'd0,
      SETTLE = 2'd1,
      URST   = 2'd2,
      RUN    = 2'd3
   } sel_state_t;

   localparam int DEF_ADDR_W     = 10;
   localparam int DEF_ADDR_MAX   = 1023;
   localparam int DEF_SETTLE_CYC = 4;
   localparam int DEF_RST_CYC    = 8;

`ifdef TT_USER_SEL_SYNC_EN
   localparam int SYNC_STAGES = 2;
`else
   localparam int SYNC_STAGES = 1;
`endif

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/tt_user_sel_sync.sv
// Per-input register chain: STAGES flops, cleared by the async reset.
module tt_user_sel_sync #(
   parameter int unsigned STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] stg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stg <= '0;
      end else begin
         stg[0] <= d;
         for (int unsigned i = 1; i < STAGES; i++) begin
            stg[i] <= stg[i-1];
         end
      end
   end

   assign q = stg[STAGES-1];

endmodule

// File: rtl/tt_user_sel.sv
// User-module address selector: saturating address counter plus settle / user-reset sequencing.
// Build option TT_USER_SEL_SYNC_EN selects 2-flop input synchronizers instead of single registers.
module tt_user_sel
   import tt_user_sel_pkg::*;
#(
   parameter int ADDR_W     = DEF_ADDR_W,
   parameter int ADDR_MAX   = DEF_ADDR_MAX,
   parameter int SETTLE_CYC = DEF_SETTLE_CYC,
   parameter int RST_CYC    = DEF_RST_CYC
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              sel_rst_i,
   input  logic              sel_inc_i,
   input  logic              ena_i,
   output logic [ADDR_W-1:0] addr_o,
   output logic              addr_vld_o,
   output logic              um_ena_o,
   output logic              um_rst_n_o
);

   localparam int CNT_W = $clog2(max2(SETTLE_CYC, RST_CYC) + 1);
   localparam logic [CNT_W-1:0]  SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
   localparam logic [CNT_W-1:0]  URST_LAST   = CNT_W'(RST_CYC - 1);
   localparam logic [ADDR_W-1:0] ADDR_TOP    = ADDR_W'(ADDR_MAX);

   logic sel_rst_s, sel_inc_s, ena_s;

   tt_user_sel_sync #(.STAGES(SYNC_STAGES)) u_sync_rst (
      .clk (clk), .rst (rst), .d (sel_rst_i), .q (sel_rst_s)
   );
   tt_user_sel_sync #(.STAGES(SYNC_STAGES)) u_sync_inc (
      .clk (clk), .rst (rst), .d (sel_inc_i), .q (sel_inc_s)
   );
   tt_user_sel_sync #(.STAGES(SYNC_STAGES)) u_sync_ena (
      .clk (clk), .rst (rst), .d (ena_i), .q (ena_s)
   );

   logic             inc_prev, inc_evt, rst_req;
   logic             addr_chg;
   sel_state_t       state_q, state_nx;
   logic [CNT_W-1:0] cnt_q, cnt_nx;

   // Edge pulse and clear request are registered once more so addr_o moves SYNC+2 edges after sampling.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         inc_prev <= 1'b0;
         inc_evt  <= 1'b0;
         rst_req  <= 1'b0;
      end else begin
         inc_prev <= sel_inc_s;
         inc_evt  <= sel_inc_s & ~inc_prev;
         rst_req  <= sel_rst_s;
      end
   end

   assign addr_chg = inc_evt & ~rst_req & (addr_o != ADDR_TOP);

   always_comb begin
      state_nx = state_q;
      cnt_nx   = cnt_q;
      if (rst_req) begin
         state_nx = CLEAR;
         cnt_nx   = '0;
      end else begin
         case (state_q)
            CLEAR: begin
               state_nx = SETTLE;
               cnt_nx   = '0;
            end
            SETTLE: begin
               if (addr_chg) begin
                  cnt_nx = '0;
               end else if (cnt_q == SETTLE_LAST) begin
                  state_nx = URST;
                  cnt_nx   = '0;
               end else begin
                  cnt_nx = cnt_q + CNT_W'(1);
               end
            end
            URST: begin
               if (addr_chg) begin
                  state_nx = SETTLE;
                  cnt_nx   = '0;
               end else if (cnt_q == URST_LAST) begin
                  state_nx = RUN;
                  cnt_nx   = '0;
               end else begin
                  cnt_nx = cnt_q + CNT_W'(1);
               end
            end
            RUN: begin
               if (addr_chg) begin
                  state_nx = SETTLE;
                  cnt_nx   = '0;
               end
            end
            default: begin
               state_nx = CLEAR;
               cnt_nx   = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= CLEAR;
         cnt_q      <= '0;
         addr_o     <= '0;
         addr_vld_o <= 1'b0;
         um_ena_o   <= 1'b0;
         um_rst_n_o <= 1'b0;
      end else begin
         state_q <= state_nx;
         cnt_q   <= cnt_nx;
         if (rst_req) begin
            addr_o <= '0;
         end else if (addr_chg) begin
            addr_o <= addr_o + ADDR_W'(1);
         end
         addr_vld_o <= (state_nx == RUN);
         um_rst_n_o <= (state_nx == RUN);
         um_ena_o   <= ena_s & ((state_nx == URST) | (state_nx == RUN));
      end
   end

endmodule

// File: tb/tb_tt_user_sel.sv
// Scoreboard bench for tt_user_sel: a time-since-change reference model queues expected outputs.
module tb_tt_user_sel;

   localparam int ADDR_W     = 4;
   localparam int ADDR_MAX   = 11;
   localparam int SETTLE_CYC = 4;
   localparam int RST_CYC    = 8;
   localparam int SYNC       = tt_user_sel_pkg::SYNC_STAGES;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              sel_rst_i = 1'b0;
   logic              sel_inc_i = 1'b0;
   logic              ena_i = 1'b0;
   logic [ADDR_W-1:0] addr_o;
   logic              addr_vld_o, um_ena_o, um_rst_n_o;

   tt_user_sel #(
      .ADDR_W     (ADDR_W),
      .ADDR_MAX   (ADDR_MAX),
      .SETTLE_CYC (SETTLE_CYC),
      .RST_CYC    (RST_CYC)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .sel_rst_i  (sel_rst_i),
      .sel_inc_i  (sel_inc_i),
      .ena_i      (ena_i),
      .addr_o     (addr_o),
      .addr_vld_o (addr_vld_o),
      .um_ena_o   (um_ena_o),
      .um_rst_n_o (um_rst_n_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      int addr;
      bit ena;
      bit rst_n;
      bit vld;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_errors++;
         $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
      end
   endtask

   // Reference model: inputs reach the core after fixed delays; outputs depend on
   // whether a clear is pending and on the cycles elapsed since the last address change.
   bit   rh[8], ih[8], eh[8];
   int   m_addr, m_since;
   bit   m_clear;
   bit   r_eff, i_eff, e_eff, chg, run;
   exp_t e_new;

   initial begin
      forever begin
         @(posedge clk or posedge rst);
         if (rst) begin
            for (int i = 0; i < 8; i++) begin
               rh[i] = 1'b0; ih[i] = 1'b0; eh[i] = 1'b0;
            end
            m_addr = 0; m_since = 0; m_clear = 1'b1;
            e_new.addr = 0; e_new.ena = 1'b0; e_new.rst_n = 1'b0; e_new.vld = 1'b0;
            exp_q.delete();
            exp_q.push_back(e_new);
         end else begin
            for (int i = 7; i > 0; i--) begin
               rh[i] = rh[i-1]; ih[i] = ih[i-1]; eh[i] = eh[i-1];
            end
            rh[0] = sel_rst_i; ih[0] = sel_inc_i; eh[0] = ena_i;
            r_eff = rh[SYNC+1];
            i_eff = ih[SYNC+1] && !ih[SYNC+2];
            e_eff = eh[SYNC];
            if (r_eff) begin
               m_addr = 0; m_clear = 1'b1; m_since = 0;
            end else begin
               chg = i_eff && (m_addr < ADDR_MAX);
               if (chg) m_addr = m_addr + 1;
               if (m_clear || chg) m_since = 0;
               else if (m_since < 1000) m_since = m_since + 1;
               m_clear = 1'b0;
            end
            run = !m_clear && (m_since >= SETTLE_CYC + RST_CYC);
            e_new.addr  = m_addr;
            e_new.ena   = e_eff && !m_clear && (m_since >= SETTLE_CYC);
            e_new.rst_n = run;
            e_new.vld   = run;
            exp_q.push_back(e_new);
         end
      end
   end

   exp_t e_got;
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         e_got = exp_q.pop_front();
         check("addr_o",     32'(addr_o),     32'(e_got.addr));
         check("um_ena_o",   32'(um_ena_o),   32'(e_got.ena));
         check("um_rst_n_o", 32'(um_rst_n_o), 32'(e_got.rst_n));
         check("addr_vld_o", 32'(addr_vld_o), 32'(e_got.vld));
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic pulse_inc(input int hi, input int lo);
      sel_inc_i = 1'b1;
      step(hi);
      sel_inc_i = 1'b0;
      step(lo);
   endtask

   task automatic clear_addr();
      sel_rst_i = 1'b1;
      step(4);
      sel_rst_i = 1'b0;
      step(2);
   endtask

   initial begin
      step(5);
      rst = 1'b0;
      step(3);

      // long clear request with ena high, then settle and user reset
      ena_i = 1'b1;
      sel_rst_i = 1'b1;
      step(10);
      sel_rst_i = 1'b0;
      step(20);

      // three increments spaced six cycles apart
      for (int p = 0; p < 3; p++) pulse_inc(1, 5);
      step(20);

      // saturation at ADDR_MAX
      clear_addr();
      for (int p = 0; p < 13; p++) pulse_inc(2, 2);
      step(20);
      @(negedge clk);
      check("addr_sat", 32'(addr_o), 32'(ADDR_MAX));
      check("run_after_sat", 32'(addr_vld_o), 32'd1);
      step(1);

      // clear and increment arriving together at addr 7
      clear_addr();
      for (int p = 0; p < 7; p++) pulse_inc(2, 2);
      step(15);
      sel_rst_i = 1'b1;
      sel_inc_i = 1'b1;
      step(5);
      sel_rst_i = 1'b0;
      sel_inc_i = 1'b0;
      step(20);

      // ena toggling in RUN
      for (int t = 0; t < 6; t++) begin
         ena_i = ~ena_i;
         step(3 + t);
      end
      ena_i = 1'b1;
      step(5);

      // async reset mid-RUN at addr 5
      clear_addr();
      for (int p = 0; p < 5; p++) pulse_inc(2, 2);
      step(20);
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("rst_addr",  32'(addr_o),     32'd0);
      check("rst_vld",   32'(addr_vld_o), 32'd0);
      check("rst_ena",   32'(um_ena_o),   32'd0);
      check("rst_rst_n", 32'(um_rst_n_o), 32'd0);
      step(3);
      rst = 1'b0;
      step(20);

      // randomized bursts followed by quiet periods
      for (int b = 0; b < 20; b++) begin
         for (int c = 0; c < 15; c++) begin
            sel_rst_i = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 2) == 0) sel_inc_i = ~sel_inc_i;
            if ($urandom_range(0, 7) == 0) ena_i = ~ena_i;
            step(1);
         end
         sel_rst_i = 1'b0;
         sel_inc_i = 1'b0;
         if ($urandom_range(0, 3) == 0) ena_i = ~ena_i;
         step(18);
      end

      step(5);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/tt_user_sel.md
TT_USER_SEL -- requirements
Module: tt_user_sel

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, address width.
REQ-002 SHALL have parameter ADDR_MAX, default 1023, highest selectable address.
REQ-003 SHALL have parameter SETTLE_CYC, default 4, cycles the address must be stable before user reset starts.
REQ-004 SHALL have parameter RST_CYC, default 8, cycles um_rst_n_o is held low after settling.
REQ-005 SHALL have port clk, input, 1, single clock.
REQ-006 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-007 SHALL have port sel_rst_i, input, 1, level request to clear the address to 0.
REQ-008 SHALL have port sel_inc_i, input, 1, address increment strobe, rising-edge sensitive.
REQ-009 SHALL have port ena_i, input, 1, global user enable.
REQ-010 SHALL have port addr_o, output, ADDR_W, current selected user-module address.
REQ-011 SHALL have port addr_vld_o, output, 1, high only in RUN.
REQ-012 SHALL have port um_ena_o, output, 1, ena to the selected user module.
REQ-013 SHALL have port um_rst_n_o, output, 1, active-low reset to the selected user module.

Function
REQ-014 SHALL register sel_rst_i, sel_inc_i and ena_i through the input stage (see Configuration), giving sel_rst_s, sel_inc_s and ena_s.
REQ-015 SHALL detect sel_inc rising edge as sel_inc_s=1 and its previous-cycle value=0.
REQ-016 SHALL, while sel_rst_s=1, load addr 0 and ignore increment edges; reset wins on simultaneous events.
REQ-017 SHALL, on a detected increment edge, set addr to addr+1, saturating at ADDR_MAX with no wrap to 0.
REQ-018 SHALL treat an increment at ADDR_MAX as no address change, so the FSM is not restarted.
REQ-019 SHALL implement FSM states CLEAR, SETTLE, URST and RUN.
REQ-020 CLEAR SHALL be entered while sel_rst_s=1; it leaves to SETTLE when sel_rst_s falls.
REQ-021 SETTLE SHALL count SETTLE_CYC cycles, then go to URST; any address change restarts the count.
REQ-022 URST SHALL count RST_CYC cycles, then go to RUN; an address change returns the FSM to SETTLE.
REQ-023 RUN SHALL persist until an address change (go to SETTLE) or sel_rst_s=1 (go to CLEAR).
REQ-024 um_rst_n_o SHALL be 1 only in RUN.
REQ-025 um_ena_o SHALL equal ena_s in URST and RUN, and 0 otherwise.
REQ-026 addr_vld_o SHALL equal (state==RUN).
REQ-027 All outputs SHALL be registered.
REQ-028 Latency: addr_o SHALL change on the (SYNC+2)th rising edge after the input edge is first sampled, where SYNC is the number of input sync stages.
REQ-029 RUN SHALL be reached exactly SETTLE_CYC+RST_CYC cycles after the last address change.
REQ-030 ena_s toggling SHALL never alter FSM state or addr.

Reset
REQ-031 While rst=1, the block SHALL asynchronously force: addr_o=0, state=CLEAR, counters=0, um_ena_o=0, um_rst_n_o=0, addr_vld_o=0, and all sync/edge flops=0.
REQ-032 Reset deassertion SHALL be followed by normal CLEAR exit behaviour; reset mid-SETTLE/URST/RUN SHALL abort immediately.

Configuration
REQ-033 With TT_USER_SEL_SYNC_EN defined, the input stage SHALL be a 2-flop synchronizer per input (SYNC=2).
REQ-034 Without TT_USER_SEL_SYNC_EN, the input stage SHALL be a single register per input (SYNC=1), and inputs SHALL be clk-synchronous.

Structure
REQ-035 A shared package tt_user_sel_pkg SHALL hold the FSM state enum (CLEAR, SETTLE, URST, RUN) and the default timing constants.
REQ-036 The per-input synchronizer SHALL be the sub-module tt_user_sel_sync, parameterised by stage count.

Verification (ADDR_W=4, ADDR_MAX=11, SETTLE_CYC=4, RST_CYC=8, TT_USER_SEL_SYNC_EN defined)
REQ-037 rst pulse mid-RUN at addr 5 -> all outputs 0 in the same cycle; addr_o=0 and state CLEAR after release.
REQ-038 sel_rst_i high 10 cycles, then low, with ena_i=1 -> um_ena_o rises 4 cycles after CLEAR exit, um_rst_n_o and addr_vld_o rise 12 cycles after CLEAR exit, addr_o=0.
REQ-039 3 increment pulses spaced 6 cycles apart -> addr_o steps 1,2,3, each on the 4th edge after the pulse; RUN is entered 12 cycles after the third change.
REQ-040 13 increment pulses from 0 -> addr_o stops at 11; the 12th and 13th pulses leave RUN undisturbed.
REQ-041 sel_rst_i and sel_inc_i rising in the same cycle at addr 7 -> addr_o=0 and state CLEAR.
REQ-042 ena_i toggled in RUN -> um_ena_o follows with 2-cycle delay; um_rst_n_o stays 1 and addr_o is unchanged.
